regs_mp: RTL and testbench
==========================

Name: regs_mp

Overview:
- Parametrised successor to the single-write-port CPU register file.
- Generalised data width and depth; two write ports (ALU writeback and load return).
- Combinational read ports: two operand ports plus a debug read port, with optional write-through bypass.
- Per-register pending scoreboard for the pipelined datapath, and a saturating committed-write counter.
- Sits between decode/issue and writeback in the pipelined CPU.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and issues; 0 = register 0 is ordinary

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
L_S  in  1  write enable, port A (writeback, high priority)
Wt_addr  in  ADDR_W  write address, port A
Wt_data  in  DATA_W  write data, port A
L_S_B  in  1  write enable, port B (load return, low priority)
Wt_addr_B  in  ADDR_W  write address, port B
Wt_data_B  in  DATA_W  write data, port B
R_addr_A  in  ADDR_W  read address A
R_addr_B  in  ADDR_W  read address B
R_addr_D  in  ADDR_W  debug read address
issue_en  in  1  mark destination register pending
issue_addr  in  ADDR_W  destination register being issued
rdata_A  out  DATA_W  read data A
rdata_B  out  DATA_W  read data B
rdata_D  out  DATA_W  debug read data (never bypassed)
busy_A  out  1  pending status of R_addr_A
busy_B  out  1  pending status of R_addr_B
wr_cnt  out  16  committed-write count, saturating

Behaviour:
- Reset (rst=1, asynchronous): all registers, all pending bits and wr_cnt clear to 0 immediately.
  - Consequently rdata_A/B/D = 0 and busy_A/B = 0 while rst is high.
  - A write or issue coinciding with reset is lost.
- Effective writes:
  - Port A is effective when L_S=1 and not (ZERO_REG=1 and Wt_addr=0); same rule for port B with its own inputs.
  - Effective port A write: register updates on rising clk edge.
  - Effective port B write: register updates on the same edge, unless port A writes the same address that cycle. Then port A data is stored and port B is dropped.
- Reads are asynchronous/combinational, zero latency:
  - ZERO_REG=1 and address 0: read returns 0.
  - Else, BYPASS=1 and the address matches an effective port A write this cycle: returns Wt_data.
  - Else, BYPASS=1 and the address matches an effective port B write (not overridden by port A): returns Wt_data_B.
  - Else: returns the stored value.
- rdata_D always returns the stored value (still 0 for r0 when ZERO_REG=1).
- Scoreboard:
  - Pending bit set on the edge when issue_en=1 (issue to r0 ignored when ZERO_REG=1).
  - Pending bit cleared on the edge for each register written by an effective write.
  - Issue and write to the same register in the same cycle: set wins; the register remains pending for the new producer.
- busy_X = pending[R_addr_X], forced 0 when either condition holds:
  - BYPASS=1 and the read is served from a write port this cycle.
  - The address is r0 with ZERO_REG=1.
- wr_cnt:
  - Increments by the number of stored writes per edge (0, 1 or 2; a dropped port B write does not count).
  - Saturates at 16'hFFFF, no wrap.
- Writes to the same register on consecutive cycles: each edge stores; the last value wins.

Test Plan:
- Reset, then L_S=1, Wt_addr=5, Wt_data=32'hA5A5A5A5; next cycle Wt_addr=6, Wt_data=32'h55AA55AA; then L_S=0, R_addr_A=5, R_addr_B=6 -> rdata_A=32'hA5A5A5A5, rdata_B=32'h55AA55AA, wr_cnt=2.
- L_S=1, Wt_addr=0, Wt_data=32'hAAAA5555 (ZERO_REG=1) -> R_addr_A=0 reads 0, rdata_D(0)=0, wr_cnt unchanged.
- BYPASS=1: L_S=1, Wt_addr=7, Wt_data=32'h12345678, R_addr_A=7 in the same cycle -> rdata_A=32'h12345678 before the edge; rdata_D(7) still shows the old value until the edge.
- Same cycle: L_S=1 writes r9=32'h1 and L_S_B=1 writes r9=32'h2 -> r9=32'h1 after the edge, wr_cnt +1. Ports to r9 and r10 -> both stored, wr_cnt +2.
- issue_en=1, issue_addr=3 -> busy_A=1 for R_addr_A=3 next cycle. Later L_S_B=1 to r3 with issue_en=1 to r3 in the same cycle -> r3 written, busy stays 1. Next write to r3 with no issue -> busy_A=0.
- Assert rst mid-sequence, between edges, after loading r5 and pending r3 -> immediately rdata=0, busy=0, wr_cnt=0. Writes resume normally after rst deasserts.

Source files
------------

// File: rtl/regs_mp.sv
// Dual-write-port register file with combinational operand/debug reads, optional write bypass,
// per-register pending scoreboard and a saturating committed-write counter.
module regs_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              L_S,
    input  logic [ADDR_W-1:0] Wt_addr,
    input  logic [DATA_W-1:0] Wt_data,
    input  logic              L_S_B,
    input  logic [ADDR_W-1:0] Wt_addr_B,
    input  logic [DATA_W-1:0] Wt_data_B,
    input  logic [ADDR_W-1:0] R_addr_A,
    input  logic [ADDR_W-1:0] R_addr_B,
    input  logic [ADDR_W-1:0] R_addr_D,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B,
    output logic [DATA_W-1:0] rdata_D,
    output logic              busy_A,
    output logic              busy_B,
    output logic [15:0]       wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pending_q, pending_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [16:0]       cnt_sum;
    logic              we_a, we_b, issue_eff;
    logic              hit_a_ra, hit_b_ra, hit_a_rb, hit_b_rb;
    logic              zero_ra, zero_rb;

    always_comb begin
        we_a      = L_S && !(ZERO_REG && (Wt_addr == '0));
        // Port B loses a same-address collision with port A.
        we_b      = L_S_B && !(ZERO_REG && (Wt_addr_B == '0)) && !(we_a && (Wt_addr_B == Wt_addr));
        issue_eff = issue_en && !(ZERO_REG && (issue_addr == '0));
    end

    always_comb begin
        zero_ra  = ZERO_REG && (R_addr_A == '0);
        zero_rb  = ZERO_REG && (R_addr_B == '0);
        hit_a_ra = BYPASS && we_a && (R_addr_A == Wt_addr);
        hit_b_ra = BYPASS && we_b && (R_addr_A == Wt_addr_B);
        hit_a_rb = BYPASS && we_a && (R_addr_B == Wt_addr);
        hit_b_rb = BYPASS && we_b && (R_addr_B == Wt_addr_B);

        rdata_A = '0;
        rdata_B = '0;
        rdata_D = '0;
        busy_A  = 1'b0;
        busy_B  = 1'b0;
        // Bypass data is live even during reset, so outputs are gated explicitly.
        if (!rst) begin
            if (zero_ra)       rdata_A = '0;
            else if (hit_a_ra) rdata_A = Wt_data;
            else if (hit_b_ra) rdata_A = Wt_data_B;
            else               rdata_A = regs_q[R_addr_A];

            if (zero_rb)       rdata_B = '0;
            else if (hit_a_rb) rdata_B = Wt_data;
            else if (hit_b_rb) rdata_B = Wt_data_B;
            else               rdata_B = regs_q[R_addr_B];

            rdata_D = regs_q[R_addr_D];
            busy_A  = pending_q[R_addr_A] && !zero_ra && !hit_a_ra && !hit_b_ra;
            busy_B  = pending_q[R_addr_B] && !zero_rb && !hit_a_rb && !hit_b_rb;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (we_a)      pending_d[Wt_addr]    = 1'b0;
        if (we_b)      pending_d[Wt_addr_B]  = 1'b0;
        // A new producer issued in the same cycle keeps the register pending.
        if (issue_eff) pending_d[issue_addr] = 1'b1;

        cnt_sum  = {1'b0, wr_cnt_q} + 17'(we_a) + 17'(we_b);
        wr_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (we_a) regs_q[Wt_addr]   <= Wt_data;
            if (we_b) regs_q[Wt_addr_B] <= Wt_data_B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            pending_q <= pending_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regs_mp.sv
// Bench for regs_mp: directed vectors with literal expectations plus a per-cycle
// comparison against an array-based reference model of the register file.
module tb_regs_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              L_S, L_S_B, issue_en;
    logic [ADDR_W-1:0] Wt_addr, Wt_addr_B, R_addr_A, R_addr_B, R_addr_D, issue_addr;
    logic [DATA_W-1:0] Wt_data, Wt_data_B;
    logic [DATA_W-1:0] rdata_A, rdata_B, rdata_D;
    logic              busy_A, busy_B;
    logic [15:0]       wr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    regs_mp #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (1'b1),
        .ZERO_REG(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .L_S       (L_S),
        .Wt_addr   (Wt_addr),
        .Wt_data   (Wt_data),
        .L_S_B     (L_S_B),
        .Wt_addr_B (Wt_addr_B),
        .Wt_data_B (Wt_data_B),
        .R_addr_A  (R_addr_A),
        .R_addr_B  (R_addr_B),
        .R_addr_D  (R_addr_D),
        .issue_en  (issue_en),
        .issue_addr(issue_addr),
        .rdata_A   (rdata_A),
        .rdata_B   (rdata_B),
        .rdata_D   (rdata_D),
        .busy_A    (busy_A),
        .busy_B    (busy_B),
        .wr_cnt    (wr_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: register contents, pending flags and write count as plain arrays/ints.
    logic [DATA_W-1:0] m_regs [32];
    bit                m_pend [32];
    int                m_cnt;

    function automatic bit eff_a();
        return L_S && (Wt_addr != 0);
    endfunction

    function automatic bit eff_b();
        return L_S_B && (Wt_addr_B != 0) && !(eff_a() && Wt_addr_B == Wt_addr);
    endfunction

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (rst || a == 0)            return '0;
        if (eff_a() && a == Wt_addr)   return Wt_data;
        if (eff_b() && a == Wt_addr_B) return Wt_data_B;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input logic [ADDR_W-1:0] a);
        if (rst || a == 0) return 1'b0;
        if ((eff_a() && a == Wt_addr) || (eff_b() && a == Wt_addr_B)) return 1'b0;
        return m_pend[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_cnt = 0;
        end else begin
            bit a_ok, b_ok;
            a_ok = eff_a();
            b_ok = eff_b();
            if (a_ok) begin m_regs[Wt_addr] = Wt_data; m_pend[Wt_addr] = 1'b0; end
            if (b_ok) begin m_regs[Wt_addr_B] = Wt_data_B; m_pend[Wt_addr_B] = 1'b0; end
            if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
            m_cnt = m_cnt + int'(a_ok) + int'(b_ok);
            if (m_cnt > 65535) m_cnt = 65535;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        check("cyc_rdata_A", 64'(rdata_A), 64'(exp_read(R_addr_A)));
        check("cyc_rdata_B", 64'(rdata_B), 64'(exp_read(R_addr_B)));
        check("cyc_rdata_D", 64'(rdata_D), rst ? 64'h0 : 64'(m_regs[R_addr_D]));
        check("cyc_busy_A", 64'(busy_A), 64'(exp_busy(R_addr_A)));
        check("cyc_busy_B", 64'(busy_B), 64'(exp_busy(R_addr_B)));
        check("cyc_wr_cnt", 64'(wr_cnt), rst ? 64'h0 : 64'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        L_S = 0; L_S_B = 0; issue_en = 0;
    endtask

    task automatic wr_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        L_S = 1; Wt_addr = a; Wt_data = d;
    endtask

    task automatic wr_b(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        L_S_B = 1; Wt_addr_B = a; Wt_data_B = d;
    endtask

    initial begin
        rst = 1;
        L_S = 0; L_S_B = 0; issue_en = 0;
        Wt_addr = 0; Wt_addr_B = 0; Wt_data = 0; Wt_data_B = 0;
        R_addr_A = 0; R_addr_B = 0; R_addr_D = 0; issue_addr = 0;
        step();
        step();
        R_addr_A = 5;
        wr_a(5, 32'hDEAD_BEEF);
        #1;
        check("reset_rdata_A", 64'(rdata_A), 64'h0);
        check("reset_wr_cnt", 64'(wr_cnt), 64'h0);
        idle();
        #2 rst = 0;

        // Two sequential port A writes.
        step();
        wr_a(5, 32'hA5A5_A5A5);
        step();
        wr_a(6, 32'h55AA_55AA);
        step();
        idle(); R_addr_A = 5; R_addr_B = 6;
        #1;
        check("r5_value", 64'(rdata_A), 64'hA5A5_A5A5);
        check("r6_value", 64'(rdata_B), 64'h55AA_55AA);
        check("cnt_after_two", 64'(wr_cnt), 64'd2);

        // Writes to r0 are discarded.
        wr_a(0, 32'hAAAA_5555);
        step();
        idle(); R_addr_A = 0; R_addr_D = 0;
        #1;
        check("r0_read", 64'(rdata_A), 64'h0);
        check("r0_debug", 64'(rdata_D), 64'h0);
        check("cnt_r0_unchanged", 64'(wr_cnt), 64'd2);

        // Bypass on the operand port, debug port shows stored value.
        wr_a(7, 32'h1234_5678); R_addr_A = 7; R_addr_D = 7;
        #1;
        check("bypass_A", 64'(rdata_A), 64'h1234_5678);
        check("debug_old", 64'(rdata_D), 64'h0);
        step();
        idle();
        #1;
        check("debug_new", 64'(rdata_D), 64'h1234_5678);

        // Same-address collision: port A wins, counted once.
        wr_a(9, 32'h1); wr_b(9, 32'h2); R_addr_A = 9;
        #1;
        check("collision_bypass", 64'(rdata_A), 64'h1);
        step();
        idle();
        #1;
        check("collision_r9", 64'(rdata_A), 64'h1);
        check("collision_cnt", 64'(wr_cnt), 64'd4);
        wr_a(9, 32'h11); wr_b(10, 32'h22); R_addr_B = 10;
        step();
        idle();
        #1;
        check("dual_r9", 64'(rdata_A), 64'h11);
        check("dual_r10", 64'(rdata_B), 64'h22);
        check("dual_cnt", 64'(wr_cnt), 64'd6);

        // Scoreboard.
        issue_en = 1; issue_addr = 3; R_addr_A = 3;
        step();
        idle();
        #1;
        check("busy_after_issue", 64'(busy_A), 64'h1);
        wr_b(3, 32'h33); issue_en = 1; issue_addr = 3;
        #1;
        check("busy_masked_bypass", 64'(busy_A), 64'h0);
        step();
        idle();
        #1;
        check("r3_written", 64'(rdata_A), 64'h33);
        check("busy_reissued", 64'(busy_A), 64'h1);
        wr_a(3, 32'h44);
        step();
        idle();
        #1;
        check("busy_cleared", 64'(busy_A), 64'h0);
        check("cnt_scoreboard", 64'(wr_cnt), 64'd8);

        // Asynchronous reset between edges.
        issue_en = 1; issue_addr = 3;
        step();
        idle(); R_addr_A = 5; R_addr_B = 3;
        #1;
        check("pre_rst_busy", 64'(busy_B), 64'h1);
        rst = 1;
        #1;
        check("rst_rdata_A", 64'(rdata_A), 64'h0);
        check("rst_busy_B", 64'(busy_B), 64'h0);
        check("rst_wr_cnt", 64'(wr_cnt), 64'h0);
        #3 rst = 0;
        step();
        wr_a(5, 32'h0000_BEEF);
        step();
        idle();
        #1;
        check("post_rst_r5", 64'(rdata_A), 64'h0000_BEEF);
        check("post_rst_cnt", 64'(wr_cnt), 64'd1);

        // Random traffic, checked by the per-cycle compare.
        for (int n = 0; n < 400; n++) begin
            L_S        = 1'($urandom);
            L_S_B      = 1'($urandom);
            issue_en   = 1'($urandom);
            Wt_addr    = 5'($urandom_range(0, 7));
            Wt_addr_B  = 5'($urandom_range(0, 7));
            issue_addr = 5'($urandom_range(0, 7));
            Wt_data    = $urandom;
            Wt_data_B  = $urandom;
            R_addr_A   = 5'($urandom_range(0, 7));
            R_addr_B   = 5'($urandom_range(0, 7));
            R_addr_D   = 5'($urandom_range(0, 7));
            step();
        end
        idle();

        // Saturation: 32768 dual writes add 65536 to a small count.
        for (int n = 0; n < 32768; n++) begin
            wr_a(1, n); wr_b(2, ~n);
            step();
        end
        idle();
        step();
        #1;
        check("cnt_saturated", 64'(wr_cnt), 64'hFFFF);
        wr_a(4, 32'h4);
        step();
        idle();
        #1;
        check("cnt_no_wrap", 64'(wr_cnt), 64'hFFFF);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
